// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default width.
package md_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIN  = 2'b10
   } md_state_e;

   function automatic logic md_is_mul(input md_op_e op);
      return ~op[1];
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO. One operand bit per RUN cycle on
// unsigned magnitudes; sign correction and the HI/LO write happen in FIN.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               bzero_q, bzero_d;
   logic [WIDTH-1:0]   a_mag_q, a_mag_d;
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               in_signed, a_neg, b_neg;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= MD_MULT;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         bzero_q <= 1'b0;
         a_mag_q <= '0;
         b_mag_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         bzero_q <= bzero_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d    = op_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      bzero_d = bzero_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      in_signed = md_is_signed(md_op_e'(op));
      a_neg     = in_signed & a[WIDTH-1];
      b_neg     = in_signed & b[WIDTH-1];

      // Multiply: upper half accumulates, whole accumulator shifts right each step.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_mag_q[0] ? {1'b0, a_mag_q} : '0);
      // Restoring divide: upper half is the partial remainder, lower half collects quotient bits.
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_mag_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_mag_q};

      prod = neg_q ? -acc_q : acc_q;
      quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = md_op_e'(op);
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               bzero_d = (b == '0);
               a_mag_d = a_neg ? -a : a;
               b_mag_d = b_neg ? -b : b;
               acc_d   = '0;
               cnt_d   = '0;
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (md_is_mul(op_q)) begin
               acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
               b_mag_d = b_mag_q >> 1;
            end else begin
               a_mag_d = a_mag_q << 1;
               if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end
         ST_FIN: begin
            done_d = 1'b1;
            if (md_is_mul(op_q)) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else begin
               // With a zero divisor the remainder path already reproduces the dividend.
               hi_d = rem;
               lo_d = bzero_q ? '1 : quot;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q != ST_IDLE);
      done = done_q;
      hi   = hi_q;
      lo   = lo_q;
   end

endmodule
